// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the TS sync acquisition path.
package ts_pkg;

    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } ts_state_e;

endpackage

// File: rtl/ts_sync_lock.sv
// Finds TS packet alignment in a raw byte stream by locating repeated sync bytes,
// then re-emits the stream with a head-of-packet strobe once alignment is confirmed.
module ts_sync_lock
    import ts_pkg::*;
#(
    parameter int unsigned PKT_LEN      = TS_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE    = TS_SYNC_BYTE,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned UNLOCK_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        ts_valid,
    output logic        ts_sync,
    output logic [7:0]  ts_data,
    output logic        locked,
    output logic [31:0] pkt_cnt,
    output logic [15:0] sync_err_cnt
);

    localparam int unsigned POS_W  = $clog2(PKT_LEN);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(PKT_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]  BAD_UNLOCK = BAD_W'(UNLOCK_COUNT);

    ts_state_e         state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic              ts_valid_q, ts_valid_d;
    logic              ts_sync_q, ts_sync_d;
    logic [7:0]        ts_data_q, ts_data_d;
    logic              locked_q, locked_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       sync_err_q, sync_err_d;

    logic              is_sync;
    logic              at_head;
    logic              emit;
    logic              emit_head;
    logic [POS_W-1:0]  pos_inc;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            pos_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            ts_valid_q <= 1'b0;
            ts_sync_q  <= 1'b0;
            ts_data_q  <= 8'd0;
            locked_q   <= 1'b0;
            pkt_cnt_q  <= 32'd0;
            sync_err_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            ts_valid_q <= ts_valid_d;
            ts_sync_q  <= ts_sync_d;
            ts_data_q  <= ts_data_d;
            locked_q   <= locked_d;
            pkt_cnt_q  <= pkt_cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        good_d     = good_q;
        bad_d      = bad_q;
        sync_err_d = sync_err_q;
        emit       = 1'b0;
        emit_head  = 1'b0;

        is_sync  = (in_data == SYNC_BYTE);
        at_head  = (pos_q == '0);
        pos_inc  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        good_inc = good_q + GOOD_W'(1);
        bad_inc  = bad_q + BAD_W'(1);

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        pos_d  = POS_W'(1);
                        good_d = GOOD_W'(1);
                        if (LOCK_COUNT == 32'd1) begin
                            state_d   = LOCK;
                            bad_d     = '0;
                            emit      = 1'b1;
                            emit_head = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    pos_d = pos_inc;
                    if (at_head) begin
                        // A non-sync byte at the expected head can never start a new hunt.
                        if (is_sync) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_LOCK) begin
                                state_d   = LOCK;
                                bad_d     = '0;
                                emit      = 1'b1;
                                emit_head = 1'b1;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCK: begin
                    pos_d     = pos_inc;
                    emit      = 1'b1;
                    emit_head = at_head;
                    if (at_head) begin
                        if (is_sync) begin
                            bad_d = '0;
                        end else begin
                            // Flywheel: keep framing through isolated misses.
                            bad_d      = bad_inc;
                            sync_err_d = (sync_err_q == 16'hFFFF) ? sync_err_q
                                                                  : sync_err_q + 16'd1;
                            if (bad_inc == BAD_UNLOCK) begin
                                state_d   = HUNT;
                                emit      = 1'b0;
                                emit_head = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        ts_valid_d = emit;
        ts_sync_d  = emit_head;
        ts_data_d  = emit ? in_data : ts_data_q;
        pkt_cnt_d  = emit_head ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
        locked_d   = (state_d == LOCK);
    end

    assign ts_valid     = ts_valid_q;
    assign ts_sync      = ts_sync_q;
    assign ts_data      = ts_data_q;
    assign locked       = locked_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign sync_err_cnt = sync_err_q;

endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed bench for ts_sync_lock: acquisition, flywheel, unlock/relock, reset and single-confirm lock.
module tb_ts_sync_lock;
    import ts_pkg::*;

    localparam int unsigned PL = 188;
    localparam logic [7:0]  SB = 8'h47;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        ts_valid, ts_sync, locked;
    logic [7:0]  ts_data;
    logic [31:0] pkt_cnt;
    logic [15:0] sync_err_cnt;

    logic        ts_valid_b, ts_sync_b, locked_b;
    logic [7:0]  ts_data_b;
    logic [31:0] pkt_cnt_b;
    logic [15:0] sync_err_cnt_b;

    int n_checks;
    int n_pass;
    int emit_cnt;
    int head_cnt;
    int idle_err;
    int e_snap;

    logic       obs_valid, obs_sync, obs_locked;
    logic [7:0] obs_data;

    ts_sync_lock dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .ts_valid     (ts_valid),
        .ts_sync      (ts_sync),
        .ts_data      (ts_data),
        .locked       (locked),
        .pkt_cnt      (pkt_cnt),
        .sync_err_cnt (sync_err_cnt)
    );

    ts_sync_lock #(.PKT_LEN(4), .LOCK_COUNT(1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .ts_valid     (ts_valid_b),
        .ts_sync      (ts_sync_b),
        .ts_data      (ts_data_b),
        .locked       (locked_b),
        .pkt_cnt      (pkt_cnt_b),
        .sync_err_cnt (sync_err_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pay(input int i);
        return 8'((i * 5) % 64);
    endfunction

    function automatic logic [7:0] garb(input int i);
        return 8'((i * 3 + 1) % 64);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive one byte, capture the registered response, then idle for the rest of the gap.
    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        obs_valid  = ts_valid;
        obs_sync   = ts_sync;
        obs_data   = ts_data;
        obs_locked = locked;
        if (ts_valid) begin
            emit_cnt++;
            if (ts_sync) head_cnt++;
        end
        in_valid = 1'b0;
        for (int k = 1; k < gap; k++) begin
            @(negedge clk);
            if (ts_valid) idle_err++;
        end
    endtask

    task automatic body(input int from, input int gap);
        for (int i = from; i < PL; i++) send(pay(i), gap);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(negedge clk);
        rst      = 1'b0;
        emit_cnt = 0;
        head_cnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0; emit_cnt = 0; head_cnt = 0; idle_err = 0; e_snap = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_valid",  32'(ts_valid), 32'd0);
        check("rst_sync",   32'(ts_sync), 32'd0);
        check("rst_data",   32'(ts_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pkt",    pkt_cnt, 32'd0);
        check("rst_err",    32'(sync_err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean stream, one byte every 4 clocks
        for (int p = 0; p < 7; p++) begin
            send(SB, 4);
            if (p == 1) begin
                check("t1_pre_locked", 32'(obs_locked), 32'd0);
                check("t1_pre_valid",  32'(obs_valid), 32'd0);
            end
            if (p == 2) begin
                check("t1_lock_valid",  32'(obs_valid), 32'd1);
                check("t1_lock_sync",   32'(obs_sync), 32'd1);
                check("t1_lock_data",   32'(obs_data), 32'(SB));
                check("t1_lock_locked", 32'(obs_locked), 32'd1);
            end
            if (p == 3) begin
                send(pay(1), 4);
                check("t1_body_valid", 32'(obs_valid), 32'd1);
                check("t1_body_sync",  32'(obs_sync), 32'd0);
                check("t1_body_data",  32'(obs_data), 32'(pay(1)));
                body(2, 4);
            end else begin
                body(1, 4);
            end
        end
        check("t1_heads",   32'(head_cnt), 32'd5);
        check("t1_bytes",   32'(emit_cnt), 32'(5 * PL));
        check("t1_pkt_cnt", pkt_cnt, 32'd5);
        check("t1_err_cnt", 32'(sync_err_cnt), 32'd0);

        // Garbage prefix with a stray sync byte at index 10
        do_reset();
        for (int i = 0; i < 50; i++) send((i == 10) ? SB : garb(i), 1);
        for (int p = 0; p < 5; p++) begin
            send(SB, 1);
            if (p == 2) begin
                check("t2_p2_valid",  32'(obs_valid), 32'd0);
                check("t2_p2_locked", 32'(obs_locked), 32'd0);
            end
            if (p == 3) begin
                check("t2_lock_valid",  32'(obs_valid), 32'd1);
                check("t2_lock_sync",   32'(obs_sync), 32'd1);
                check("t2_lock_locked", 32'(obs_locked), 32'd1);
                check("t2_no_early",    32'(emit_cnt), 32'd1);
            end
            body(1, 1);
        end
        check("t2_pkt_cnt", pkt_cnt, 32'd2);

        // Single corrupted sync while locked
        do_reset();
        for (int p = 0; p < 8; p++) begin
            send((p == 5) ? 8'h00 : SB, 1);
            if (p == 5) begin
                check("t3_valid",  32'(obs_valid), 32'd1);
                check("t3_sync",   32'(obs_sync), 32'd1);
                check("t3_data",   32'(obs_data), 32'd0);
                check("t3_locked", 32'(obs_locked), 32'd1);
                check("t3_err",    32'(sync_err_cnt), 32'd1);
            end
            body(1, 1);
        end
        check("t3_end_locked", 32'(locked), 32'd1);
        check("t3_end_err",    32'(sync_err_cnt), 32'd1);
        check("t3_pkt_cnt",    pkt_cnt, 32'd6);

        // Three consecutive misses drop lock; relock after restore
        do_reset();
        for (int p = 0; p < 11; p++) begin
            if (p == 7) e_snap = emit_cnt;
            send((p >= 5 && p <= 7) ? 8'h00 : SB, 1);
            case (p)
                5: begin
                    check("t4_m1_sync", 32'(obs_sync), 32'd1);
                    check("t4_m1_err",  32'(sync_err_cnt), 32'd1);
                end
                6: begin
                    check("t4_m2_valid",  32'(obs_valid), 32'd1);
                    check("t4_m2_locked", 32'(obs_locked), 32'd1);
                    check("t4_m2_err",    32'(sync_err_cnt), 32'd2);
                end
                7: begin
                    check("t4_m3_valid",  32'(obs_valid), 32'd0);
                    check("t4_m3_locked", 32'(obs_locked), 32'd0);
                    check("t4_m3_err",    32'(sync_err_cnt), 32'd3);
                end
                8: begin
                    check("t4_r1_valid",  32'(obs_valid), 32'd0);
                    check("t4_r1_locked", 32'(obs_locked), 32'd0);
                end
                9: check("t4_r2_valid", 32'(obs_valid), 32'd0);
                10: begin
                    check("t4_relock_valid",  32'(obs_valid), 32'd1);
                    check("t4_relock_sync",   32'(obs_sync), 32'd1);
                    check("t4_relock_locked", 32'(obs_locked), 32'd1);
                    check("t4_gap_emits",     32'(emit_cnt - e_snap), 32'd1);
                end
                default: ;
            endcase
            body(1, 1);
        end
        check("t4_pkt_cnt", pkt_cnt, 32'd6);

        // Asynchronous reset mid-packet while locked
        do_reset();
        for (int p = 0; p < 4; p++) begin
            send(SB, 1);
            body(1, 1);
        end
        send(SB, 1);
        for (int i = 1; i <= 50; i++) send(pay(i), 1);
        check("t5_pre_valid", 32'(obs_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_valid",  32'(ts_valid), 32'd0);
        check("t5_rst_data",   32'(ts_data), 32'd0);
        check("t5_rst_locked", 32'(locked), 32'd0);
        check("t5_rst_pkt",    pkt_cnt, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        emit_cnt = 0;
        body(51, 1);
        for (int p = 5; p < 8; p++) begin
            send(SB, 1);
            if (p == 5) begin
                check("t5_h1_valid",  32'(obs_valid), 32'd0);
                check("t5_h1_locked", 32'(obs_locked), 32'd0);
            end
            if (p == 6) check("t5_h2_valid", 32'(obs_valid), 32'd0);
            if (p == 7) begin
                check("t5_lock_valid",  32'(obs_valid), 32'd1);
                check("t5_lock_locked", 32'(obs_locked), 32'd1);
                check("t5_no_early",    32'(emit_cnt), 32'd1);
            end
            body(1, 1);
        end

        // Single-confirmation lock, back-to-back bytes, 4-byte packets
        do_reset();
        send(8'h12, 1);
        check("t6_pre_valid",  32'(ts_valid_b), 32'd0);
        check("t6_pre_locked", 32'(locked_b), 32'd0);
        send(SB, 1);
        check("t6_valid",  32'(ts_valid_b), 32'd1);
        check("t6_sync",   32'(ts_sync_b), 32'd1);
        check("t6_data",   32'(ts_data_b), 32'(SB));
        check("t6_locked", 32'(locked_b), 32'd1);
        check("t6_pkt",    pkt_cnt_b, 32'd1);
        send(pay(1), 1);
        check("t6_body_valid", 32'(ts_valid_b), 32'd1);
        check("t6_body_sync",  32'(ts_sync_b), 32'd0);
        send(pay(2), 1);
        send(pay(3), 1);
        send(SB, 1);
        check("t6_head2_sync", 32'(ts_sync_b), 32'd1);
        check("t6_head2_pkt",  pkt_cnt_b, 32'd2);

        check("idle_pulse", 32'(idle_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ts_sync_lock.md
# ts_sync_lock

TS byte-stream sync acquisition stage, placed directly upstream of `dvb_s2_wrap` in the `ts_clk_h264out` domain. Takes the raw byte stream from the H.264 encoder, which carries no packet framing. Hunts for the 0x47 sync byte at packet-length spacing and declares lock after a configurable number of confirmations. Then emits `valid`/`sync`/`data`, aligned to packet heads, ready for `ts_valid_h264out`/`ts_syn_h264out`/`ts_din_h264out`.

## Interface
- `PKT_LEN`, 188, TS packet length in bytes (≥ 2)
- `SYNC_BYTE`, 8'h47, sync byte value
- `LOCK_COUNT`, 3, consecutive correct sync bytes (including the first) needed for lock, ≥ 1
- `UNLOCK_COUNT`, 3, consecutive missing sync bytes that drop lock, ≥ 1
- `clk` in 1: byte clock (encoder TS clock)
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: input byte strobe
- `in_data` in 8: input byte
- `ts_valid` out 1: output byte strobe (reset 0)
- `ts_sync` out 1: asserted with first byte of each packet (reset 0)
- `ts_data` out 8: output byte (reset 0)
- `locked` out 1: LOCK state indicator (reset 0)
- `pkt_cnt` out 32: packets emitted, wraps at 2^32 (reset 0)
- `sync_err_cnt` out 16: sync-byte misses while locked, saturates at 16'hFFFF (reset 0)

## Operation
- All state advances only on cycles with `in_valid`=1; idle cycles change nothing, and `ts_valid`=0 on them.
- `pos`: byte position within the packet, 0..PKT_LEN-1, wraps PKT_LEN-1 → 0. `good`/`bad`: confirmation counters.
- States:
  - HUNT
    - If `in_data`==SYNC_BYTE: `pos`←1, `good`←1.
      - If LOCK_COUNT==1, go to LOCK and emit this byte as a head.
      - Otherwise go to VERIFY.
    - Other bytes are discarded.
  - VERIFY
    - `pos` advances on each byte. Bytes are not emitted.
    - At `pos`==0 with a matching byte: `good`+1. When `good` reaches LOCK_COUNT, go to LOCK, `bad`←0, and emit this byte with `ts_sync`=1.
    - At `pos`==0 with a mismatch: back to HUNT, evaluating the same byte as HUNT would. If the byte equals SYNC_BYTE it cannot be at `pos`==0 in HUNT's sense, so it is simply dropped and the hunt resumes on the next byte.
  - LOCK
    - Every valid byte is emitted, with `ts_sync`=(`pos`==0).
    - At `pos`==0 with a matching byte: `bad`←0.
    - At `pos`==0 with a mismatch (flywheel):
      - `bad`+1 and `sync_err_cnt`+1 (saturating).
      - If `bad` reaches UNLOCK_COUNT: go to HUNT and do not emit this byte; the packet in progress is not finished.
      - Otherwise emit the byte with `ts_sync`=1.
- `pkt_cnt` increments on every emitted head byte (`ts_valid`&`ts_sync`).
- `locked`=1 exactly while in LOCK (registered with the state).
- Reset mid-operation: all outputs and state clear immediately (asynchronous). The next byte is evaluated in HUNT.

## Timing
- Outputs are registered, with 1-cycle latency: an input byte at clock edge n appears on `ts_*` after edge n+1.
- `ts_valid` is a single-cycle pulse per emitted byte. Throughput is one byte per clock; back-to-back input is accepted.
- Lock latency from a clean stream: the first head is emitted (LOCK_COUNT-1)·PKT_LEN bytes after the first sync byte.
- `locked` rises in the same cycle as the first emitted `ts_sync`. It falls in the cycle after the UNLOCK_COUNT-th miss is sampled.

## Structure
- Shared package `ts_pkg`: TS_PKT_LEN=188, TS_SYNC_BYTE=8'h47, and the state enum {HUNT, VERIFY, LOCK} as a 2-bit localparam encoding.
- No sub-module. The state machine, position counter, and output register live in one module.
- `pos` width is $clog2(PKT_LEN). `good`/`bad` widths are $clog2(max count + 1).

## Test plan
- Clean stream of 7 packets, one byte every 4 clocks, 0x47 at offset 0:
  - `locked` rises at the head of packet 3.
  - 5 packets are emitted, each with `ts_sync` on the 0x47 byte.
  - `pkt_cnt`=5, `sync_err_cnt`=0.
- Stream prefixed with 50 garbage bytes including a stray 0x47 at byte 10:
  - VERIFY fails at byte 198 and the hunt restarts.
  - Lock is still reached on the true alignment.
  - No bytes are emitted before lock.
- Locked stream with a single corrupted sync (0x00) in packet 5:
  - That byte is emitted with `ts_sync`=1.
  - `sync_err_cnt`=1 and `locked` stays 1.
- Locked stream with 3 consecutive corrupted syncs:
  - `locked` falls on the third miss, and that byte is not emitted.
  - Re-lock occurs 2 packets after the sync bytes are restored.
- `rst` pulsed mid-packet while locked:
  - All outputs are 0 immediately.
  - After release, the bench requires a full re-acquisition (3 sync bytes) before any `ts_valid`.
- LOCK_COUNT=1, back-to-back valid bytes: the first 0x47 is emitted with `ts_sync`=1 one clock later, and `locked`=1 in the same cycle.
